// File: rtl/ball_engine.sv
// Pong ball motion engine: owns ball position/velocity, advances once per frame tick,
// reflects off walls and paddles, and pulses the scorer when a paddle misses.
module ball_engine #(
  parameter logic [9:0] SCREENWIDTH  = 10'd640,
  parameter logic [9:0] SCREENHEIGHT = 10'd480,
  parameter logic [9:0] PADDLESIZE   = 10'd64,
  parameter logic [9:0] BALLSIZE     = 10'd8,
  parameter logic [9:0] PADDLE_L_X   = 10'd16,
  parameter logic [9:0] PADDLE_R_X   = 10'd624,
  parameter logic [2:0] SPEED        = 3'd2,
  parameter logic [5:0] MISSDELAY    = 6'd60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  input  logic       serve,
  input  logic       serve_dir,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_active,
  output logic       score_l,
  output logic       score_r
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MOVE = 2'd1;
  localparam logic [1:0] ST_MISS = 2'd2;

  localparam logic signed [10:0] C_HB    = $signed({2'b00, BALLSIZE[9:1]});
  localparam logic signed [10:0] C_CX    = $signed({2'b00, SCREENWIDTH[9:1]});
  localparam logic signed [10:0] C_CY    = $signed({2'b00, SCREENHEIGHT[9:1]});
  localparam logic signed [10:0] C_XMAX  = $signed({1'b0, SCREENWIDTH}) - 11'sd1 - C_HB;
  localparam logic signed [10:0] C_YMAX  = $signed({1'b0, SCREENHEIGHT}) - 11'sd1 - C_HB;
  localparam logic signed [10:0] C_LB    = $signed({1'b0, PADDLE_L_X}) + C_HB;
  localparam logic signed [10:0] C_RB    = $signed({1'b0, PADDLE_R_X}) - C_HB;
  localparam logic signed [10:0] C_REACH = $signed({2'b00, PADDLESIZE[9:1]}) + C_HB;
  localparam logic signed [10:0] C_QTR   = $signed({3'b000, PADDLESIZE[9:2]});
  localparam logic signed [10:0] C_SPEED = $signed({8'd0, SPEED});

  logic [1:0]        r_state;
  logic [9:0]        r_x;
  logic [9:0]        r_y;
  logic              r_dir;
  logic signed [2:0] r_dy;
  logic [5:0]        r_cnt;
  logic              r_active;
  logic              r_score_l;
  logic              r_score_r;

  logic signed [10:0] w_nx;
  logic signed [10:0] w_ny;
  logic signed [10:0] w_off;
  logic signed [10:0] w_abs;
  logic signed [2:0]  w_hit_dy;
  logic               w_cross;
  logic               w_hit;
  logic               w_miss;
  logic [1:0]         w_state_n;
  logic [9:0]         w_x_n;
  logic [9:0]         w_y_n;
  logic               w_dir_n;
  logic signed [2:0]  w_dy_n;
  logic [5:0]         w_cnt_n;
  logic               w_score_l_n;
  logic               w_score_r_n;

  // Candidate next position and the paddle/miss decisions for the current frame.
  always_comb begin
    if (r_dir) begin
      w_nx = $signed({1'b0, r_x}) - C_SPEED;
    end else begin
      w_nx = $signed({1'b0, r_x}) + C_SPEED;
    end
    w_ny = $signed({1'b0, r_y}) + $signed({{8{r_dy[2]}}, r_dy});
    if (r_dir) begin
      w_off   = w_ny - $signed({1'b0, paddle_l_y});
      w_cross = ($signed({1'b0, r_x}) > C_LB) && (w_nx <= C_LB);
    end else begin
      w_off   = w_ny - $signed({1'b0, paddle_r_y});
      w_cross = ($signed({1'b0, r_x}) < C_RB) && (w_nx >= C_RB);
    end
    w_abs = w_off[10] ? -w_off : w_off;
    if (w_abs > C_QTR) begin
      w_hit_dy = w_off[10] ? -3'sd2 : 3'sd2;
    end else begin
      w_hit_dy = w_off[10] ? -3'sd1 : 3'sd1;
    end
    w_hit  = w_cross && (w_abs <= C_REACH);
    w_miss = !w_hit && (r_dir ? (w_nx <= C_HB) : (w_nx >= C_XMAX));
  end

  // Frame state machine: serve, motion with bounces, miss freeze.
  always_comb begin
    w_state_n   = r_state;
    w_x_n       = r_x;
    w_y_n       = r_y;
    w_dir_n     = r_dir;
    w_dy_n      = r_dy;
    w_cnt_n     = r_cnt;
    w_score_l_n = 1'b0;
    w_score_r_n = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (serve) begin
          w_state_n = ST_MOVE;
          w_x_n     = C_CX[9:0];
          w_y_n     = C_CY[9:0];
          w_dir_n   = serve_dir;
          w_dy_n    = 3'sd1;
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      ST_MOVE: begin
        if (advance) begin
          if (w_ny < C_HB) begin
            w_y_n  = C_HB[9:0];
            w_dy_n = -r_dy;
          end else if (w_ny > C_YMAX) begin
            w_y_n  = C_YMAX[9:0];
            w_dy_n = -r_dy;
          end else begin
            w_y_n = w_ny[9:0];
          end
          // Paddle dy rule deliberately overrides any wall reflection above.
          if (w_hit) begin
            w_x_n   = r_dir ? C_LB[9:0] : C_RB[9:0];
            w_dir_n = ~r_dir;
            w_dy_n  = w_hit_dy;
          end else if (w_miss) begin
            w_x_n       = r_dir ? C_HB[9:0] : C_XMAX[9:0];
            w_state_n   = ST_MISS;
            w_cnt_n     = MISSDELAY;
            w_score_l_n = ~r_dir;
            w_score_r_n = r_dir;
          end else begin
            w_x_n = w_nx[9:0];
          end
        end else begin
          w_state_n = ST_MOVE;
        end
      end
      ST_MISS: begin
        if (advance) begin
          if (r_cnt <= 6'd1) begin
            w_state_n = ST_IDLE;
            w_cnt_n   = 6'd0;
            w_x_n     = C_CX[9:0];
            w_y_n     = C_CY[9:0];
          end else begin
            w_cnt_n = r_cnt - 6'd1;
          end
        end else begin
          w_state_n = ST_MISS;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_x       <= C_CX[9:0];
      r_y       <= C_CY[9:0];
      r_dir     <= 1'b0;
      r_dy      <= 3'sd1;
      r_cnt     <= 6'd0;
      r_active  <= 1'b0;
      r_score_l <= 1'b0;
      r_score_r <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_x       <= w_x_n;
      r_y       <= w_y_n;
      r_dir     <= w_dir_n;
      r_dy      <= w_dy_n;
      r_cnt     <= w_cnt_n;
      r_active  <= (w_state_n == ST_MOVE);
      r_score_l <= w_score_l_n;
      r_score_r <= w_score_r_n;
    end
  end

  assign ball_x      = r_x;
  assign ball_y      = r_y;
  assign ball_active = r_active;
  assign score_l     = r_score_l;
  assign score_r     = r_score_r;

endmodule

// File: tb/tb_ball_engine.sv
// Randomized scoreboard bench for ball_engine against a frame-level reference model.
module tb_ball_engine;
  logic       clk = 1'b0;
  logic       reset;
  logic       advance;
  logic       serve;
  logic       serve_dir;
  logic [9:0] paddle_l_y;
  logic [9:0] paddle_r_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       ball_active;
  logic       score_l;
  logic       score_r;

  ball_engine dut (
    .clk(clk), .reset(reset), .advance(advance), .serve(serve), .serve_dir(serve_dir),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y), .ball_x(ball_x), .ball_y(ball_y),
    .ball_active(ball_active), .score_l(score_l), .score_r(score_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit act;
    bit sl;
    bit sr;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: ball as plain integers, "moving" flag and a freeze frame count.
  int mx, my, mdy, frozen;
  bit mdir, moving;
  bit m_sl, m_sr;

  function automatic void model_reset();
    mx = 320; my = 240; mdir = 1'b0; mdy = 1; moving = 1'b0; frozen = 0;
    m_sl = 1'b0; m_sr = 1'b0;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void model_step(input bit rst, input bit srv, input bit sdir, input bit adv,
                                     input int pl, input int pr);
    int nx, ny, off, py;
    bit crossed;
    m_sl = 1'b0;
    m_sr = 1'b0;
    if (rst) begin
      model_reset();
    end else if (!moving && frozen == 0) begin
      if (srv) begin
        moving = 1'b1; mx = 320; my = 240; mdir = sdir; mdy = 1;
      end
    end else if (moving) begin
      if (adv) begin
        nx = mdir ? mx - 2 : mx + 2;
        ny = my + mdy;
        if (ny < 4) begin
          my = 4; mdy = -mdy;
        end else if (ny > 475) begin
          my = 475; mdy = -mdy;
        end else begin
          my = ny;
        end
        py = mdir ? pl : pr;
        off = ny - py;
        crossed = mdir ? (mx > 20 && nx <= 20) : (mx < 620 && nx >= 620);
        if (crossed && iabs(off) <= 36) begin
          mx = mdir ? 20 : 620;
          mdir = !mdir;
          mdy = ((iabs(off) > 16) ? 2 : 1) * ((off < 0) ? -1 : 1);
        end else if (mdir && nx <= 4) begin
          mx = 4; m_sr = 1'b1; moving = 1'b0; frozen = 60;
        end else if (!mdir && nx >= 635) begin
          mx = 635; m_sl = 1'b1; moving = 1'b0; frozen = 60;
        end else begin
          mx = nx;
        end
      end
    end else begin
      if (adv) begin
        frozen = frozen - 1;
        if (frozen == 0) begin
          mx = 320; my = 240;
        end
      end
    end
  endfunction

  function automatic int far_pad(input int y);
    return (y < 240) ? 470 : 10;
  endfunction

  function automatic int near_pad(input int y);
    int p;
    p = y + int'($urandom_range(0, 100)) - 50;
    if (p < 0) p = 0;
    if (p > 479) p = 479;
    return p;
  endfunction

  task automatic step(input bit rst, input bit srv, input bit sdir, input bit adv,
                      input int pl, input int pr);
    exp_t e;
    @(negedge clk);
    reset = rst; serve = srv; serve_dir = sdir; advance = adv;
    paddle_l_y = 10'(pl); paddle_r_y = 10'(pr);
    model_step(rst, srv, sdir, adv, pl, pr);
    e.x = mx; e.y = my; e.act = moving; e.sl = m_sl; e.sr = m_sr;
    q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: every clock the DUT presents a new frame state; compare with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        if (int'(ball_x) != e.x || int'(ball_y) != e.y || ball_active != e.act ||
            score_l != e.sl || score_r != e.sr) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t: got x=%0d y=%0d act=%0b sl=%0b sr=%0b expected x=%0d y=%0d act=%0b sl=%0b sr=%0b",
                   $time, ball_x, ball_y, ball_active, score_l, score_r, e.x, e.y, e.act, e.sl, e.sr);
        end
      end
    end
  end

  initial begin
    bit track_l, track_r;
    int pl, pr, budget;
    reset = 1'b1; serve = 1'b0; serve_dir = 1'b0; advance = 1'b0;
    paddle_l_y = 10'd0; paddle_r_y = 10'd0;
    model_reset();

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    #1;
    check("reset_x", int'(ball_x), 320);
    check("reset_y", int'(ball_y), 240);
    check("reset_active", int'(ball_active), 0);
    check("reset_scores", int'({score_l, score_r}), 0);

    // Straight serve to the right, ten frames.
    step(1'b0, 1'b1, 1'b0, 1'b0, 10, 10);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 10, 10);
    @(posedge clk);
    #2;
    check("serve10_x", int'(ball_x), 340);
    check("serve10_y", int'(ball_y), 250);
    check("serve10_active", int'(ball_active), 1);

    // Random rallies: paddles track the ball loosely or sit far away.
    for (int i = 0; i < 6000; i++) begin
      track_l = ($urandom_range(0, 3) != 0);
      track_r = ($urandom_range(0, 3) != 0);
      pl = track_l ? near_pad(my) : far_pad(my);
      pr = track_r ? near_pad(my) : far_pad(my);
      step(($urandom_range(0, 1999) == 0), ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 7), pl, pr);
    end

    // Serve held high throughout; wait for the freeze counter to reach 30, then reset.
    budget = 0;
    while (!(frozen == 30 && !moving) && budget < 3000) begin
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1, far_pad(my), far_pad(my));
      budget++;
    end
    check("miss_reached_budget", int'(budget < 3000), 1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 10, 10);
    #1;
    check("async_reset_x", int'(ball_x), 320);
    check("async_reset_y", int'(ball_y), 240);
    check("async_reset_active", int'(ball_active), 0);
    check("async_reset_scores", int'({score_l, score_r}), 0);

    // Relaunch leftwards, then hold serve high with no frame ticks.
    step(1'b0, 1'b1, 1'b1, 1'b0, 10, 10);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 1'b0, 1'b1, far_pad(my), far_pad(my));
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 1'b0, near_pad(my), near_pad(my));
    @(posedge clk);
    #2;
    check("hold_x", int'(ball_x), mx);
    check("hold_y", int'(ball_y), my);
    check("hold_active", int'(ball_active), 1);

    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #3;
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
